// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: state encoding, frame sizes and the baud divisor helper.
// Frame length depends on UART_TX_PARITY_EN (adds an even-parity bit when defined).
package uart_defs;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Kept here so a future receiver derives the identical divisor.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: pulses bit_tick for one cycle on the last clock of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_divisor
        $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
    end

    logic [CW-1:0] cnt;

    assign bit_tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || bit_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined); tx and busy are flop outputs.
module uart_tx
    import uart_defs::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be >= 2");
    end

    state_t     state, state_d;
    logic [7:0] shift, shift_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic       tx_d, busy_d;
    logic       bit_tick;
`ifdef UART_TX_PARITY_EN
    logic       par, par_d;
`endif

    // Counter is held at zero while idle so the start bit gets a full period.
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_cnt_d = bit_cnt;
        tx_d      = tx;
        busy_d    = busy;
`ifdef UART_TX_PARITY_EN
        par_d     = par;
`endif
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    tx_d    = shift[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift >> 1;
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_cnt <= bit_cnt_d;
            tx      <= tx_d;
            busy    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks/bit; frame model built from the bit list of each byte.
module tb_uart_tx;

    localparam int CLK_FREQ  = 1000;
    localparam int BAUD_RATE = 100;
    localparam int N         = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int L = FB * N;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      name;
        logic [7:0] d;
        logic [7:0] hold;
        int         ign;
        int         tail;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx       (tx),
        .busy     (busy)
    );

    // Line level c cycles after the accepting edge: each frame bit lasts N cycles.
    function automatic logic model_tx(input logic [7:0] d, input int c);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        q.push_back(^d);
`endif
        q.push_back(1'b1);
        if (c >= 1 && c <= L) return q[(c - 1) / N];
        return 1'b1;
    endfunction

    function automatic logic model_busy(input int c);
        return (c >= 1 && c <= L);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called at a falling edge; leaves the bench at the falling edge of cycle L+tail.
    task automatic frame(input string name, input logic [7:0] d, input logic [7:0] hold,
                         input int ign, input int tail);
        int tx_err = 0, busy_err = 0, busy_cnt = 0, first_tx = -1;
        tx_data  = d;
        tx_start = 1'b1;
        for (int c = 1; c <= L + tail; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tx_start = 1'b0;
                tx_data  = hold;
            end
            if (tx !== model_tx(d, c)) begin
                tx_err++;
                if (first_tx < 0) first_tx = c;
            end
            if (busy !== model_busy(c)) busy_err++;
            if (busy === 1'b1) busy_cnt++;
            if (c == ign) begin
                tx_start = 1'b1;
                tx_data  = 8'h3C;
            end else if (c == ign + 1) begin
                tx_start = 1'b0;
                tx_data  = hold;
            end
        end
        if (tx_err != 0) $display("  %s: first line deviation at cycle %0d", name, first_tx);
        check({name, " tx bad cycles"}, tx_err, 0);
        check({name, " busy bad cycles"}, busy_err, 0);
        check({name, " busy length"}, busy_cnt, L);
    endtask

    initial begin
        vecs[0] = '{name: "single A5",      d: 8'hA5, hold: 8'hA5, ign: 0,  tail: 2};
        vecs[1] = '{name: "ignored start",  d: 8'hA5, hold: 8'hA5, ign: 35, tail: 4};
        vecs[2] = '{name: "data hold",      d: 8'hA5, hold: 8'h00, ign: 0,  tail: 2};
        vecs[3] = '{name: "b2b first 00",   d: 8'h00, hold: 8'h00, ign: 0,  tail: 1};
        vecs[4] = '{name: "b2b second FF",  d: 8'hFF, hold: 8'hFF, ign: 0,  tail: 2};
        vecs[5] = '{name: "byte 07",        d: 8'h07, hold: 8'h07, ign: 0,  tail: 2};
        vecs[6] = '{name: "byte 03",        d: 8'h03, hold: 8'h03, ign: L - 1, tail: 3};

        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", int'(busy), 0);

        for (int i = 0; i < 7; i++) frame(vecs[i].name, vecs[i].d, vecs[i].hold, vecs[i].ign, vecs[i].tail);

        // Abort during data bit 3 of 0x55, then a clean frame.
        tx_data  = 8'h55;
        tx_start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) tx_start = 1'b0;
        end
        check("pre-abort bit3 level", int'(tx), 0);
        check("pre-abort busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("abort tx", int'(tx), 1);
        check("abort busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame("post-reset 81", 8'h81, 8'h81, 0, 2);

        for (int k = 0; k < 8; k++) begin
            logic [7:0] d, h;
            int ign;
            d   = 8'($urandom);
            h   = 8'($urandom);
            ign = ($urandom_range(1, 0) == 1) ? int'($urandom_range(L - 1, 2)) : 0;
            frame($sformatf("random %0d d=%02h", k, d), d, h, ign, int'($urandom_range(3, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
